// File: rtl/pwm_seq_pkg.sv
// Shared types and default constants for the PWM duty-code sequencer.
package pwm_seq_pkg;

    localparam int unsigned DEFAULT_CODE_W        = 3;
    localparam int unsigned DEFAULT_MAX_CODE      = 7;
    localparam int unsigned DEFAULT_PERIOD_CYCLES = 10;
    localparam int unsigned DEFAULT_STEP_PERIODS  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RAMP_UP,
        ST_RAMP_DOWN
    } seq_state_e;

endpackage

// File: rtl/pwm_period_timer.sv
// PWM period counter plus a step counter that paces ramp steps in whole periods.
module pwm_period_timer #(
    parameter int unsigned PERIOD_CYCLES = 10,
    parameter int unsigned STEP_PERIODS  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    input  logic step_run,
    input  logic step_clr,
    output logic period_tick,
    output logic step_due
);

    localparam int unsigned PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int unsigned SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    logic [PW-1:0] period_cnt_q, period_cnt_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;

    assign period_tick = active && (period_cnt_q == PW'(PERIOD_CYCLES - 1));
    // A tick in the accept cycle (step_clr) must not count toward the first step.
    assign step_due = period_tick && step_run && !step_clr && !clear
                      && (step_cnt_q == SW'(STEP_PERIODS - 1));

    always_comb begin
        period_cnt_d = period_cnt_q;
        step_cnt_d   = step_cnt_q;
        if (clear || !active) begin
            period_cnt_d = '0;
            step_cnt_d   = '0;
        end else begin
            period_cnt_d = period_tick ? '0 : period_cnt_q + PW'(1);
            if (step_clr || !step_run) begin
                step_cnt_d = '0;
            end else if (period_tick) begin
                step_cnt_d = step_due ? '0 : step_cnt_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt_q <= '0;
            step_cnt_q   <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
            step_cnt_q   <= step_cnt_d;
        end
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Ramps the PWM duty code toward an accepted target one code per step,
// changing it only on PWM period boundaries.
module pwm_duty_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int unsigned CODE_W        = DEFAULT_CODE_W,
    parameter int unsigned MAX_CODE      = DEFAULT_MAX_CODE,
    parameter int unsigned PERIOD_CYCLES = DEFAULT_PERIOD_CYCLES,
    parameter int unsigned STEP_PERIODS  = DEFAULT_STEP_PERIODS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CODE_W-1:0] target_code,
    input  logic              target_valid,
    output logic              target_ready,
    output logic [CODE_W-1:0] duty_code,
    output logic              duty_update,
    output logic              period_tick,
    output logic              busy,
    output logic              at_target
);

    seq_state_e        state_q, state_d;
    logic [CODE_W-1:0] duty_q, duty_d;
    logic [CODE_W-1:0] target_q, target_d;
    logic [CODE_W-1:0] clamped;
    logic              upd_q, upd_d;
    logic              accept;
    logic              ramping;
    logic              step_due;

    assign ramping      = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
    assign target_ready = (state_q == ST_HOLD) && enable;
    assign accept       = target_ready && target_valid;
    assign clamped      = (int'(target_code) > int'(MAX_CODE)) ? CODE_W'(MAX_CODE) : target_code;

    pwm_period_timer #(
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .STEP_PERIODS  (STEP_PERIODS)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (!enable),
        .active      (state_q != ST_IDLE),
        .step_run    (ramping),
        .step_clr    (accept),
        .period_tick (period_tick),
        .step_due    (step_due)
    );

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        upd_d    = 1'b0;
        // Dropping enable overrides everything, including a same-cycle accept.
        if (!enable) begin
            state_d  = ST_IDLE;
            duty_d   = '0;
            target_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_HOLD;
                ST_HOLD: begin
                    if (accept) begin
                        target_d = clamped;
                        if (clamped > duty_q)      state_d = ST_RAMP_UP;
                        else if (clamped < duty_q) state_d = ST_RAMP_DOWN;
                    end
                end
                ST_RAMP_UP: begin
                    if (step_due) begin
                        duty_d = duty_q + CODE_W'(1);
                        upd_d  = 1'b1;
                        if (duty_d == target_q) state_d = ST_HOLD;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (step_due) begin
                        duty_d = duty_q - CODE_W'(1);
                        upd_d  = 1'b1;
                        if (duty_d == target_q) state_d = ST_HOLD;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            duty_q   <= '0;
            target_q <= '0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            upd_q    <= upd_d;
        end
    end

    assign duty_code   = duty_q;
    assign duty_update = upd_q;
    assign busy        = ramping;
    assign at_target   = (state_q == ST_HOLD) && (duty_q == target_q);

endmodule
